// File: rtl/fdiv_defs.sv
// Shared definitions for the Newton-Raphson mantissa divider: widths,
// fixed-point constants, FSM encoding and the reciprocal seed rule.
package fdiv_defs;

    localparam int MANT_W   = 24;              // 1.23 mantissa
    localparam int XW       = 28;              // 1.27 reciprocal / 2.26 quotient
    localparam int PW       = MANT_W + XW;     // 2.50 product
    localparam int ITER_MIN = 1;
    localparam int ITER_MAX = 4;
    localparam logic [XW-1:0] ONE_1P27 = 28'h8000000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MUL_BX = 3'd1,
        S_MUL_XE = 3'd2,
        S_MUL_AX = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Seed for 1/b at the midpoint of bucket idx, as 0.5 + seed/512.
    // 512/(1+(i+0.5)/256) == 262144/(513+2i); the divisor is odd so never exact.
    function automatic logic [7:0] seed_of(input int unsigned idx);
        int unsigned v;
        v = 262144 / (513 + 2 * idx) - 256;
        return (v > 255) ? 8'd255 : v[7:0];
    endfunction

endpackage

// File: rtl/recip_seed_rom.sv
// 256-entry reciprocal seed table, addressed by the top mantissa fraction bits.
module recip_seed_rom
    import fdiv_defs::*;
(
    input  logic [7:0] i_addr,
    output logic [7:0] o_seed
);

    function automatic logic [255:0][7:0] build_tbl();
        logic [255:0][7:0] t;
        for (int i = 0; i < 256; i++) t[i] = seed_of(i);
        return t;
    endfunction

    // Table is folded to constants at elaboration; lookup is a pure mux.
    localparam logic [255:0][7:0] SEED_TBL = build_tbl();

    assign o_seed = SEED_TBL[i_addr];

endmodule

// File: rtl/wallace_24x28_product.sv
// Unsigned 24x28 product array; synthesis maps the product onto a
// carry-save compressor tree with a final adder.
module wallace_24x28_product
    import fdiv_defs::*;
(
    input  logic [MANT_W-1:0] i_a,
    input  logic [XW-1:0]     i_b,
    output logic [PW-1:0]     o_p
);

    assign o_p = PW'(i_a) * PW'(i_b);

endmodule

// File: rtl/newton_recip_div24.sv
// Iterative Newton-Raphson mantissa divider q = a/b. One shared multiplier is
// time-multiplexed: per iteration d=b*x, e=2-d, x=x*e; finally q=a*x.
module newton_recip_div24
    import fdiv_defs::*;
#(
    parameter int ITER = 3    // legal ITER_MIN..ITER_MAX
)
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [MANT_W-1:0] i_a,
    input  logic [MANT_W-1:0] i_b,
    output logic              o_busy,
    output logic              o_q_valid,
    output logic [XW-1:0]     o_q,
    output logic              o_q_sticky
);

    localparam logic [2:0] ITER_L = 3'(ITER);

    state_t              r_state, w_next;
    logic [MANT_W-1:0]   r_a, r_b;
    logic [XW-1:0]       r_x;        // reciprocal estimate, 1.27
    logic [MANT_W-1:0]   r_e;        // correction 2-d, upper 24 bits (1.23)
    logic [2:0]          r_it;
    logic [XW-1:0]       r_q;
    logic                r_sticky;

    logic                w_accept;
    logic [7:0]          w_seed;
    logic [MANT_W-1:0]   w_op;
    logic [PW-1:0]       w_p;
    logic [2:0]          w_it_nxt;

    assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start;
    assign w_it_nxt = r_it + 3'd1;

    recip_seed_rom u_seed (
        .i_addr (i_b[22:15]),
        .o_seed (w_seed)
    );

    // Select the 24-bit multiplicand for the current step; x is always the other operand
    always_comb begin
        w_op = r_a;
        case (r_state)
            S_MUL_BX: w_op = r_b;
            S_MUL_XE: w_op = r_e;
            default:  w_op = r_a;
        endcase
    end

    wallace_24x28_product u_mul (
        .i_a (w_op),
        .i_b (r_x),
        .o_p (w_p)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; a new request may be taken straight out of DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = S_MUL_BX;
            S_MUL_BX: w_next = S_MUL_XE;
            S_MUL_XE: w_next = (w_it_nxt < ITER_L) ? S_MUL_BX : S_MUL_AX;
            S_MUL_AX: w_next = S_DONE;
            S_DONE:   w_next = i_start ? S_MUL_BX : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Datapath registers: operands at accept, then one product result per MUL state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_x      <= '0;
            r_e      <= '0;
            r_it     <= '0;
            r_q      <= '0;
            r_sticky <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a  <= i_a;
                r_b  <= i_b;
                r_x  <= {2'b01, w_seed, 18'b0};
                r_it <= '0;
            end
            case (r_state)
                // e = 2 - d as a 28-bit two's complement wrap; only the top 24 bits feed the array
                S_MUL_BX: r_e <= MANT_W'((~w_p[50:23] + 28'd1) >> 4);
                S_MUL_XE: begin
                    r_x  <= w_p[50:23];
                    r_it <= w_it_nxt;
                end
                S_MUL_AX: begin
                    r_q      <= w_p[51:24];
                    r_sticky <= |w_p[23:0];
                end
                default: ;
            endcase
        end
    end

    assign o_busy     = (r_state == S_MUL_BX) || (r_state == S_MUL_XE) || (r_state == S_MUL_AX);
    assign o_q_valid  = (r_state == S_DONE);
    assign o_q        = r_q;
    assign o_q_sticky = r_sticky;

endmodule

// File: tb/tb_newton_recip_div24.sv
// Scoreboard bench for newton_recip_div24: three builds (ITER=3,1,4) with
// independent inputs; expected quotients come from an integer model of the
// Newton recurrence and, where flagged, a real-valued accuracy bound.
module tb_newton_recip_div24;

    localparam real TOL = 1.0 / 4194304.0;   // 2^-22

    typedef struct {
        int          inst;
        logic [27:0] q;
        logic        st;
        int          acc;
        bit          tol;
        bit          vq;
        logic [23:0] a;
        logic [23:0] b;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_s [3];
    logic [23:0] a_s     [3];
    logic [23:0] b_s     [3];
    logic        busy_s  [3];
    logic        qv_s    [3];
    logic [27:0] q_s     [3];
    logic        st_s    [3];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb [$];

    exp_t m_e;
    int   m_idx;
    real  m_err;

    newton_recip_div24 #(.ITER(3)) u_dut3 (
        .i_clk(clk), .i_rst(rst), .i_start(start_s[0]), .i_a(a_s[0]), .i_b(b_s[0]),
        .o_busy(busy_s[0]), .o_q_valid(qv_s[0]), .o_q(q_s[0]), .o_q_sticky(st_s[0]));
    newton_recip_div24 #(.ITER(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start_s[1]), .i_a(a_s[1]), .i_b(b_s[1]),
        .o_busy(busy_s[1]), .o_q_valid(qv_s[1]), .o_q(q_s[1]), .o_q_sticky(st_s[1]));
    newton_recip_div24 #(.ITER(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start_s[2]), .i_a(a_s[2]), .i_b(b_s[2]),
        .o_busy(busy_s[2]), .o_q_valid(qv_s[2]), .o_q(q_s[2]), .o_q_sticky(st_s[2]));

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int iter_of(input int k);
        return (k == 0) ? 3 : ((k == 1) ? 1 : 4);
    endfunction

    function automatic int lat_of(input int k);
        return 2 * iter_of(k) + 2;
    endfunction

    function automatic int seed_ref(input int i);
        int s;
        s = int'($floor(512.0 / (1.0 + (real'(i) + 0.5) / 256.0))) - 256;
        return (s > 255) ? 255 : s;
    endfunction

    // Newton recurrence on scaled integers: x is 1/b scaled by 2^27
    function automatic void model(input logic [23:0] a, input logic [23:0] b, input int iters,
                                  output logic [27:0] q, output logic st);
        longint unsigned x, d, e, p;
        longint unsigned m28;
        m28 = (64'd1 << 28) - 1;
        x = (64'd1 << 26) + (64'(seed_ref(int'(b[22:15]))) << 18);
        for (int i = 0; i < iters; i++) begin
            p = 64'(b) * x;
            d = (p >> 23) & m28;
            e = ((64'd1 << 28) - d) & m28;
            p = (e >> 4) * x;
            x = (p >> 23) & m28;
        end
        p  = 64'(a) * x;
        q  = 28'(p >> 24);
        st = (p & 64'hFFFFFF) != 0;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_ok(input string nm, input bit ok, input longint act, input longint exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Wait for instance k to be free, present one request, push its expectation
    task automatic issue(input int k, input logic [23:0] a, input logic [23:0] b,
                         input bit tol, input bit vq);
        int          n;
        logic [27:0] eq;
        logic        est;
        n = 0;
        @(negedge clk);
        while (busy_s[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy_s[k]) chk($sformatf("ready_timeout[%0d]", k), busy_s[k], 0);
        model(a, b, iter_of(k), eq, est);
        start_s[k] = 1'b1;
        a_s[k] = a;
        b_s[k] = b;
        sb.push_back('{k, eq, est, cyc, tol, vq, a, b});
        @(negedge clk);
        start_s[k] = 1'b0;
        a_s[k] = 24'($urandom);
        b_s[k] = 24'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every q_valid pulse retires the oldest pending request of that instance
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (qv_s[k]) begin
                    m_idx = -1;
                    for (int j = 0; j < sb.size(); j++)
                        if (m_idx < 0 && sb[j].inst == k) m_idx = j;
                    if (m_idx < 0) begin
                        chk($sformatf("unexpected_q_valid[%0d]", k), qv_s[k], 0);
                    end else begin
                        m_e = sb[m_idx];
                        sb.delete(m_idx);
                        chk($sformatf("latency[%0d]", k), cyc - m_e.acc, lat_of(k));
                        chk($sformatf("busy_in_done[%0d]", k), busy_s[k], 0);
                        if (m_e.vq) begin
                            chk($sformatf("q[%0d] a=%h b=%h", k, m_e.a, m_e.b), q_s[k], m_e.q);
                            chk($sformatf("sticky[%0d] a=%h b=%h", k, m_e.a, m_e.b), st_s[k], m_e.st);
                        end
                        if (m_e.tol) begin
                            m_err = real'(q_s[k]) / 67108864.0 - real'(m_e.a) / real'(m_e.b);
                            if (m_err < 0.0) m_err = -m_err;
                            chk_ok($sformatf("accuracy[%0d] a=%h b=%h", k, m_e.a, m_e.b),
                                   m_err < TOL, q_s[k], m_e.q);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, n;
        for (int k = 0; k < 3; k++) begin
            start_s[k] = 1'b0;
            a_s[k] = 24'h800000;
            b_s[k] = 24'h800000;
        end
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_busy[%0d]", k), busy_s[k], 0);
            chk($sformatf("rst_q_valid[%0d]", k), qv_s[k], 0);
            chk($sformatf("rst_q[%0d]", k), q_s[k], 0);
            chk($sformatf("rst_sticky[%0d]", k), st_s[k], 0);
        end
        rst = 1'b0;

        // 1 / 1: busy for 2*ITER+1 cycles, result just under 1.0
        issue(0, 24'h800000, 24'h800000, 1'b1, 1'b1);
        nb = 0;
        for (int i = 0; i < 20 && !qv_s[0]; i++) begin
            if (busy_s[0]) nb++;
            @(negedge clk);
        end
        chk("t1_busy_cycles", nb, 7);
        chk_ok("t1_q_range", q_s[0] >= 28'h3FFFFF0 && q_s[0] <= 28'h4000000, q_s[0], 28'h4000000);
        drain();

        // 1.5 / 1 and 1 / (2-ulp), also on the ITER=4 build
        issue(0, 24'hC00000, 24'h800000, 1'b1, 1'b1);
        issue(0, 24'h800000, 24'hFFFFFF, 1'b1, 1'b1);
        issue(2, 24'hC00000, 24'h800000, 1'b1, 1'b1);
        issue(2, 24'h800000, 24'hFFFFFF, 1'b1, 1'b1);
        issue(1, 24'hC00000, 24'h800000, 1'b0, 1'b1);
        // illegal mantissas still finish on schedule
        issue(0, 24'h123456, 24'h800000, 1'b0, 1'b0);
        issue(0, 24'h800000, 24'h400000, 1'b0, 1'b0);
        drain();

        // start held high for three back-to-back divisions; inputs scrambled while busy
        start_s[0] = 1'b1;
        a_s[0] = 24'hA00000;
        b_s[0] = 24'hE00000;
        begin
            logic [27:0] eq;
            logic        est;
            model(a_s[0], b_s[0], 3, eq, est);
            sb.push_back('{0, eq, est, cyc, 1'b0, 1'b1, a_s[0], b_s[0]});
            for (int r = 1; r < 3; r++) begin
                @(negedge clk);
                a_s[0] = 24'($urandom);
                b_s[0] = 24'($urandom);
                n = 0;
                while (!qv_s[0] && n < 30) begin
                    @(negedge clk);
                    n++;
                end
                if (!qv_s[0]) chk("t4_valid_timeout", qv_s[0], 1);
                a_s[0] = {1'b1, 23'($urandom)};
                b_s[0] = {1'b1, 23'($urandom)};
                model(a_s[0], b_s[0], 3, eq, est);
                sb.push_back('{0, eq, est, cyc, 1'b0, 1'b1, a_s[0], b_s[0]});
            end
        end
        @(negedge clk);
        start_s[0] = 1'b0;
        drain();

        // reset during MUL_XE: outputs clear at once, no pulse afterwards
        @(negedge clk);
        start_s[0] = 1'b1;
        a_s[0] = 24'hA00000;
        b_s[0] = 24'hC00000;
        @(negedge clk);
        start_s[0] = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_pre_busy", busy_s[0], 1);
        chk_ok("t5_pre_q_nonzero", q_s[0] != 0, q_s[0], 1);
        rst = 1'b1;
        #1;
        chk("t5_busy", busy_s[0], 0);
        chk("t5_q_valid", qv_s[0], 0);
        chk("t5_q", q_s[0], 0);
        chk("t5_sticky", st_s[0], 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("t5_post_busy", busy_s[0], 0);
        issue(0, 24'hA00000, 24'hC00000, 1'b1, 1'b1);
        drain();

        // random legal operands across all three builds
        for (int i = 0; i < 150; i++) begin
            logic [23:0] ra, rb;
            ra = {1'b1, 23'($urandom)};
            rb = {1'b1, 23'($urandom)};
            case (i % 10)
                0: rb = 24'h800000;
                1: rb = 24'hFFFFFF;
                2: ra = 24'hFFFFFF;
                default: ;
            endcase
            issue(i % 3, ra, rb, 1'b0, 1'b1);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
